// File: rtl/fir_pkg.sv
// Shared types and fixed-point helpers for the streaming FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  localparam int MAX_WL  = 32;
  localparam int MAX_ACC = 2 * MAX_WL + 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Adds half an output LSB, then an arithmetic shift, so ties round toward +inf.
  function automatic logic signed [MAX_ACC-1:0] round_shift(input logic signed [MAX_ACC-1:0] acc,
                                                            input int wl);
    logic signed [MAX_ACC-1:0] one;
    logic signed [MAX_ACC-1:0] sum;
    one = 1;
    sum = acc + (one <<< (wl - 2));
    return sum >>> (wl - 1);
  endfunction

  function automatic logic sat_ovf(input logic signed [MAX_ACC-1:0] acc, input int wl);
    logic signed [MAX_ACC-1:0] one;
    logic signed [MAX_ACC-1:0] r;
    one = 1;
    r   = round_shift(acc, wl);
    return (r > (one <<< (wl - 1)) - one) || (r < -(one <<< (wl - 1)));
  endfunction

  function automatic logic [MAX_WL-1:0] sat_round(input logic signed [MAX_ACC-1:0] acc,
                                                  input int wl);
    logic signed [MAX_ACC-1:0] one;
    logic signed [MAX_ACC-1:0] r;
    logic signed [MAX_ACC-1:0] max_v;
    logic signed [MAX_ACC-1:0] min_v;
    one   = 1;
    r     = round_shift(acc, wl);
    max_v = (one <<< (wl - 1)) - one;
    min_v = -(one <<< (wl - 1));
    if (r > max_v) return MAX_WL'(max_v);
    if (r < min_v) return MAX_WL'(min_v);
    return MAX_WL'(r);
  endfunction

endpackage

// File: rtl/fir_mac_tree.sv
// Stage-1 product registers and the combinational adder tree feeding the output stage.
module fir_mac_tree
  import fir_pkg::*;
#(
  parameter int WL   = 8,
  parameter int TAPS = 3,
  parameter int ACCW = 2 * WL + clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   adv,
  input  logic                   flush,
  input  logic                   accept,
  input  logic signed [WL-1:0]   h [TAPS],
  input  logic signed [WL-1:0]   x [TAPS],
  output logic                   p_valid,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*WL-1:0] p_q [TAPS];
  logic signed [2*WL-1:0] p_d [TAPS];
  logic                   p_valid_q;
  logic                   p_valid_d;

  always_comb begin
    p_d       = p_q;
    p_valid_d = p_valid_q;
    if (flush) begin
      p_valid_d = 1'b0;
    end else if (adv) begin
      p_valid_d = accept;
      for (int k = 0; k < TAPS; k++) p_d[k] = (2*WL)'(h[k]) * (2*WL)'(x[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_valid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) p_q[k] <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_q       <= p_d;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACCW'(p_q[k]);
  end

  assign p_valid = p_valid_q;

endmodule

// File: rtl/fir_stream_filter.sv
// Streaming direct-form FIR: load FSM, coefficient bank, delay line, handshake and output rounding.
module fir_stream_filter
  import fir_pkg::*;
#(
  parameter int WL   = 8,
  parameter int TAPS = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          coef_load,
  input  logic          coef_valid,
  input  logic [WL-1:0] coef_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_data,
  output logic          out_ovf
);

  localparam int ACCW = 2 * WL + clog2(TAPS);
  localparam int CW   = clog2(TAPS + 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic signed [WL-1:0]   h_q [TAPS];
  logic signed [WL-1:0]   h_d [TAPS];
  logic signed [WL-1:0]   x_q [TAPS];
  logic signed [WL-1:0]   x_d [TAPS];
  logic                   out_valid_q, out_valid_d;
  logic                   out_ovf_q, out_ovf_d;
  logic [WL-1:0]          out_data_q, out_data_d;
  logic                   adv, accept, flush, p_valid;
  logic signed [ACCW-1:0] acc;

  // A stalled output freezes every stage; entering LOAD from anywhere flushes them.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = (state_q == RUN) && adv;
  assign accept   = in_valid && in_ready;
  assign flush    = coef_load && (state_q != LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (coef_load) state_d = LOAD;
      LOAD:    if (!coef_load) state_d = (count_q == CW'(TAPS)) ? RUN : IDLE;
      RUN:     if (coef_load) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_d     = h_q;
    count_d = count_q;
    if (flush) begin
      for (int k = 0; k < TAPS; k++) h_d[k] = '0;
      count_d = '0;
    end else if ((state_q == LOAD) && coef_valid && (count_q != CW'(TAPS))) begin
      for (int k = 0; k < TAPS; k++)
        if (count_q == CW'(k)) h_d[k] = $signed(coef_in);
      count_d = count_q + CW'(1);
    end
  end

  // The MAC sees the post-shift window so a sample reaches out_data two edges after accept.
  always_comb begin
    x_d = x_q;
    if (flush) begin
      for (int k = 0; k < TAPS; k++) x_d[k] = '0;
    end else if (accept) begin
      x_d[0] = $signed(in_data);
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
    end
  end

  fir_mac_tree #(
    .WL   (WL),
    .TAPS (TAPS),
    .ACCW (ACCW)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv),
    .flush   (flush),
    .accept  (accept),
    .h       (h_q),
    .x       (x_d),
    .p_valid (p_valid),
    .acc     (acc)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_ovf_d   = 1'b0;
    end else if (adv) begin
      out_valid_d = p_valid;
      out_data_d  = WL'(sat_round(MAX_ACC'(acc), WL));
      out_ovf_d   = sat_ovf(MAX_ACC'(acc), WL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        h_q[k] <= '0;
        x_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      h_q         <= h_d;
      x_q         <= x_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fir_stream_filter.sv
// Self-checking bench for fir_stream_filter: scenario tasks plus an arithmetic FIR reference scoreboard.
module tb_fir_stream_filter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       coef_load = 1'b0;
  logic       coef_valid = 1'b0;
  logic [7:0] coef_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_ovf;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         h_m [3];
  int         hist [$];
  logic [8:0] exp_q [$];
  logic [8:0] exp_v;
  bit         flush_now = 1'b0;

  fir_stream_filter #(.WL(8), .TAPS(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coef_load  (coef_load),
    .coef_valid (coef_valid),
    .coef_in    (coef_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  // y = sum h[k]*x[n-k], then floor((acc + 64) / 128) and clamp to the 8-bit signed range
  function automatic logic [8:0] model_y();
    int acc, num, r;
    acc = 0;
    for (int k = 0; k < 3; k++)
      if (k < hist.size()) acc += h_m[k] * hist[k];
    num = acc + 64;
    if (num >= 0) r = num / 128;
    else          r = -((-num + 127) / 128);
    if (r > 127)  return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL scoreboard: got out_data=%h ovf=%b, expected no output", out_data, out_ovf);
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_ovf, out_data} !== exp_v)
            $display("[TB] FAIL scoreboard: got ovf=%b data=%h, expected ovf=%b data=%h",
                     out_ovf, out_data, exp_v[8], exp_v[7:0]);
          else pass_cnt++;
        end
      end
      if (flush_now) begin
        exp_q.delete();
        hist.delete();
      end else if (in_valid && in_ready) begin
        hist.push_front(int'($signed(in_data)));
        if (hist.size() > 3) void'(hist.pop_back());
        exp_q.push_back(model_y());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coefs(input int n, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2);
    logic [7:0] c [3];
    c = '{c0, c1, c2};
    in_valid   = 1'b0;
    coef_valid = 1'b0;
    coef_load  = 1'b1;
    flush_now  = 1'b1;
    tick();
    flush_now = 1'b0;
    for (int i = 0; i < n; i++) begin
      coef_valid = 1'b1;
      coef_in    = c[i];
      tick();
    end
    coef_valid = 1'b0;
    coef_load  = 1'b0;
    for (int k = 0; k < 3; k++) h_m[k] = (k < n) ? int'($signed(c[k])) : 0;
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({in_ready, out_valid, out_ovf, out_data} !== 11'h000)
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b ovf=%b data=%h, expected all 0",
               in_ready, out_valid, out_ovf, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    #10 reset_n = 1'b1;
    tick();
    in_valid = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_idle_ready: got %b, expected 0", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    load_coefs(2, 8'hEB, 8'h33, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("[TB] FAIL short_load_idle: got in_ready=%b, expected 0", in_ready);
    else pass_cnt++;
    tick();
    load_coefs(3, 8'hEB, 8'h33, 8'h1A);
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL full_load_run: got in_ready=%b, expected 1", in_ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_impulse();
    logic [7:0] y_exp [3];
    y_exp = '{8'hF6, 8'h1A, 8'h0D};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      in_data  = (i == 0) ? 8'h40 : 8'h00;
      @(negedge clk);
      if (i == 0) begin
        total_cnt++;
        if (in_ready !== 1'b1) $display("[TB] FAIL impulse_accept: got in_ready=%b, expected 1", in_ready);
        else pass_cnt++;
      end
      if (i == 1) begin
        total_cnt++;
        if (out_valid !== 1'b0) $display("[TB] FAIL impulse_latency: got out_valid=%b one cycle after accept, expected 0", out_valid);
        else pass_cnt++;
      end
      if (i >= 2 && i <= 4) begin
        total_cnt++;
        if ({out_valid, out_ovf, out_data} !== {1'b1, 1'b0, y_exp[i-2]})
          $display("[TB] FAIL impulse_y%0d: got vld=%b ovf=%b data=%h, expected vld=1 ovf=0 data=%h",
                   i - 2, out_valid, out_ovf, out_data, y_exp[i-2]);
        else pass_cnt++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_saturation();
    logic [7:0] cf [3];
    logic [7:0] xv [3];
    logic [7:0] yv [3];
    cf = '{8'h7F, 8'h80, 8'h7F};
    xv = '{8'h7F, 8'h80, 8'h80};
    yv = '{8'h7F, 8'h7F, 8'h80};
    for (int c = 0; c < 3; c++) begin
      load_coefs(3, cf[c], cf[c], cf[c]);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        in_valid = 1'b1;
        in_data  = xv[c];
        @(negedge clk);
        if (i == 4) begin
          total_cnt++;
          if ({out_valid, out_ovf, out_data} !== {1'b1, 1'b1, yv[c]})
            $display("[TB] FAIL saturate_case%0d: got vld=%b ovf=%b data=%h, expected vld=1 ovf=1 data=%h",
                     c, out_valid, out_ovf, out_data, yv[c]);
          else pass_cnt++;
        end
        tick();
      end
      drain();
    end
  endtask

  task automatic test_stall();
    logic [7:0] xs [12];
    logic [7:0] held;
    int         sent;
    load_coefs(3, 8'hEB, 8'h33, 8'h1A);
    foreach (xs[i]) xs[i] = 8'($urandom);
    sent = 0;
    held = 8'h00;
    for (int cyc = 0; cyc < 60 && (sent < 12 || cyc < 9); cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 12);
      in_data   = (sent < 12) ? xs[sent] : 8'h00;
      @(negedge clk);
      if (cyc == 4) begin
        held = out_data;
        total_cnt++;
        if (out_valid !== 1'b1) $display("[TB] FAIL stall_valid: got out_valid=%b, expected 1", out_valid);
        else pass_cnt++;
      end
      if (cyc >= 4 && cyc < 9) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("[TB] FAIL stall_ready cyc%0d: got in_ready=%b, expected 0", cyc, in_ready);
        else pass_cnt++;
      end
      if (cyc > 4 && cyc < 9) begin
        total_cnt++;
        if (out_data !== held) $display("[TB] FAIL stall_hold cyc%0d: got %h, expected %h", cyc, out_data, held);
        else pass_cnt++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    total_cnt++;
    if (sent !== 12) $display("[TB] FAIL stall_sent: got %0d accepted, expected 12", sent);
    else pass_cnt++;
    drain();
    total_cnt++;
    if (exp_q.size() !== 0) $display("[TB] FAIL stall_drain: got %0d outputs missing, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i < 4);
      in_data   = 8'($urandom);
      out_ready = (i < 4);
      tick();
    end
    in_valid  = 1'b0;
    coef_load = 1'b1;
    flush_now = 1'b1;
    tick();
    flush_now = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b00)
      $display("[TB] FAIL flush_drop: got out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    load_coefs(3, 8'h40, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 0);
      in_data  = 8'h7F;
      @(negedge clk);
      if (i == 2) begin
        total_cnt++;
        if ({out_valid, out_ovf, out_data} !== {1'b1, 1'b0, 8'h40})
          $display("[TB] FAIL flush_reload: got vld=%b ovf=%b data=%h, expected vld=1 ovf=0 data=40",
                   out_valid, out_ovf, out_data);
        else pass_cnt++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    load_coefs(3, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();
    total_cnt++;
    if (exp_q.size() !== 0) $display("[TB] FAIL random_drain: got %0d outputs missing, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    load_coefs(3, 8'hEB, 8'h33, 8'h1A);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_ovf, out_data} !== 11'h000)
      $display("[TB] FAIL async_reset: got rdy=%b vld=%b ovf=%b data=%h, expected all 0",
               in_ready, out_valid, out_ovf, out_data);
    else pass_cnt++;
    exp_q.delete();
    hist.delete();
    #3 reset_n = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("[TB] FAIL post_reset_idle: got in_ready=%b, expected 0", in_ready);
    else pass_cnt++;
    tick();
    load_coefs(2, 8'h10, 8'h20, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("[TB] FAIL post_reset_partial: got in_ready=%b, expected 0", in_ready);
    else pass_cnt++;
    tick();
    load_coefs(3, 8'h10, 8'h20, 8'hF0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    drain();
    total_cnt++;
    if (exp_q.size() !== 0) $display("[TB] FAIL post_reset_drain: got %0d outputs missing, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_impulse();
    test_saturation();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
